// File: rtl/alu_seq_if.sv
// Operand/result bundle between the execute-stage controller and alu_seq.
// The controller drives operands and start; the ALU returns results, status and HI/LO.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
);
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [3:0]       opSel;
    logic [SHW-1:0]   shamt;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output operand1, operand2, opSel, shamt, start,
        input  result, zero, overflow, busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  operand1, operand2, opSel, shamt, start,
        output result, zero, overflow, busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/alu_seq.sv
// Execute-stage ALU: single-cycle combinational ops plus an iterative
// radix-2 multiply/divide unit that writes HI/LO after WIDTH steps.
module alu_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,  OP_SUB   = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3,
        OP_SLT  = 4'd4,  OP_XOR   = 4'd5,  OP_NOR = 4'd6,  OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,  OP_SRA   = 4'd9,  OP_SLTU = 4'd10, OP_MULT = 4'd11,
        OP_MULTU = 4'd12, OP_DIV  = 4'd13, OP_DIVU = 4'd14, OP_RSVD = 4'd15
    } op_t;

    logic [WIDTH-1:0] op1, op2, res, sum, diff;
    logic [SHW-1:0]   shamt;
    logic             ovf;

    assign op1   = bus.operand1;
    assign op2   = bus.operand2;
    assign shamt = bus.shamt;

    always_comb begin
        res  = '0;
        ovf  = 1'b0;
        sum  = op1 + op2;
        diff = op1 - op2;
        case (op_t'(bus.opSel))
            OP_ADD: begin
                res = sum;
                ovf = (op1[WIDTH-1] == op2[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (op1[WIDTH-1] != op2[WIDTH-1]) && (diff[WIDTH-1] != op1[WIDTH-1]);
            end
            OP_AND:  res = op1 & op2;
            OP_OR:   res = op1 | op2;
            OP_XOR:  res = op1 ^ op2;
            OP_NOR:  res = ~(op1 | op2);
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            OP_SLL:  res = op1 << shamt;
            OP_SRL:  res = op1 >> shamt;
            OP_SRA:  res = $signed(op1) >>> shamt;
            default: res = '0;
        endcase
    end

    assign bus.result   = res;
    assign bus.zero     = (res == '0);
    assign bus.overflow = ovf;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   a_q, a_d, op1_q, op1_d, hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
    logic               dz_q, dz_d;

    logic               accept, is_signed, is_div_op, s1, s2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [WIDTH:0]     add_s, trial;
    logic [2*WIDTH-1:0] step, prod_fin;

    // prod_q is shared: {acc, multiplier} for multiply, {remainder, dividend/quotient} for divide.
    always_comb begin
        add_s = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, (prod_q[0] ? a_q : {WIDTH{1'b0}})};
        trial = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]} - {1'b0, a_q};
        if (is_div_q) begin
            step = trial[WIDTH] ? {prod_q[2*WIDTH-2:0], 1'b0}
                                : {trial[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
        end else begin
            step = {add_s, prod_q[WIDTH-1:1]};
        end
        prod_fin = neg_lo_q ? (~step + 1'b1) : step;
    end

    always_comb begin
        is_div_op = (bus.opSel == OP_DIV) || (bus.opSel == OP_DIVU);
        is_signed = (bus.opSel == OP_MULT) || (bus.opSel == OP_DIV);
        accept    = bus.start && (bus.opSel >= OP_MULT) && (bus.opSel <= OP_DIVU);
        s1        = is_signed && op1[WIDTH-1];
        s2        = is_signed && op2[WIDTH-1];
        mag1      = s1 ? (~op1 + 1'b1) : op1;
        mag2      = s2 ? (~op2 + 1'b1) : op2;

        state_d  = state_q;
        cnt_d    = cnt_q;
        prod_d   = prod_q;
        a_d      = a_q;
        op1_d    = op1_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        is_div_d = is_div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dz_d     = dz_q;

        case (state_q)
            RUN: begin
                prod_d = step;
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    if (!is_div_q) begin
                        hi_d = prod_fin[2*WIDTH-1:WIDTH];
                        lo_d = prod_fin[WIDTH-1:0];
                    end else if (dz_q) begin
                        hi_d = op1_q;
                        lo_d = '1;
                    end else begin
                        hi_d = neg_hi_q ? (~step[2*WIDTH-1:WIDTH] + 1'b1) : step[2*WIDTH-1:WIDTH];
                        lo_d = neg_lo_q ? (~step[WIDTH-1:0] + 1'b1) : step[WIDTH-1:0];
                    end
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    state_d  = RUN;
                    cnt_d    = CW'(WIDTH);
                    is_div_d = is_div_op;
                    op1_d    = op1;
                    neg_lo_d = s1 ^ s2;
                    neg_hi_d = s1;
                    dz_d     = is_div_op && (op2 == '0);
                    a_d      = is_div_op ? mag2 : mag1;
                    prod_d   = {{WIDTH{1'b0}}, (is_div_op ? mag1 : mag2)};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            a_q      <= '0;
            op1_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            a_q      <= a_d;
            op1_q    <= op1_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy        = (state_q == RUN);
    assign bus.done        = (state_q == DONE);
    assign bus.div_by_zero = (state_q == DONE) && dz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: combinational sweep plus mul/div handshake scenarios.
module tb_alu_seq;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t sb_q[$];

    alu_seq_if #(.WIDTH(W)) bus ();
    alu_seq #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t        e;
        longint      sa, sb, sq, sr;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e  = '0;
        case (op)
            4'd11: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
            4'd12: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            4'd13, 4'd14: begin
                if (b == '0) begin
                    e.lo = '1; e.hi = a; e.dz = 1'b1;
                end else if (op == 4'd13) begin
                    sq = sa / sb; sr = sa % sb; q = sq; r = sr;
                    e.lo = q[31:0]; e.hi = r[31:0];
                end else begin
                    q = {32'd0, a} / {32'd0, b}; r = {32'd0, a} % {32'd0, b};
                    e.lo = q[31:0]; e.hi = r[31:0];
                end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic launch(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.opSel    = op;
        bus.operand1 = a;
        bus.operand2 = b;
        bus.start    = 1'b1;
        sb_q.push_back(model(op, a, b));
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    task automatic collect(output int busy_cnt, output bit both, output bit tmo);
        busy_cnt = 0; both = 1'b0; tmo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (bus.busy && bus.done) both = 1'b1;
            if (bus.done) begin tmo = 1'b0; break; end
            if (bus.busy) busy_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string name, input bit chk_busy, input int busy_cnt,
                                input bit both, input bit tmo);
        exp_t e;
        checks++;
        if (tmo !== 1'b0) begin
            failures++; $display("FAIL %s timeout: done not seen within 200 cycles", name);
            return;
        end
        if (chk_busy) begin
            checks++;
            if (busy_cnt !== int'(W)) begin
                failures++; $display("FAIL %s busy_cycles got %0d want %0d", name, busy_cnt, W);
            end
        end
        checks++;
        if (both !== 1'b0) begin
            failures++; $display("FAIL %s busy_and_done got 1 want 0", name);
        end
        checks++;
        if (sb_q.size() == 0) begin
            failures++; $display("FAIL %s scoreboard empty got 0 entries want 1", name);
            return;
        end
        e = sb_q.pop_front();
        checks++;
        if (bus.hi !== e.hi) begin
            failures++; $display("FAIL %s hi got %08h want %08h", name, bus.hi, e.hi);
        end
        checks++;
        if (bus.lo !== e.lo) begin
            failures++; $display("FAIL %s lo got %08h want %08h", name, bus.lo, e.lo);
        end
        checks++;
        if (bus.div_by_zero !== e.dz) begin
            failures++; $display("FAIL %s div_by_zero got %0b want %0b", name, bus.div_by_zero, e.dz);
        end
    endtask

    task automatic test_reset();
        bus.opSel = 4'd0; bus.operand1 = '0; bus.operand2 = '0; bus.shamt = '0; bus.start = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            failures++; $display("FAIL reset_flags got %03b want 000", {bus.busy, bus.done, bus.div_by_zero});
        end
        checks++;
        if ({bus.hi, bus.lo} !== 64'd0) begin
            failures++; $display("FAIL reset_hilo got %016h want 0", {bus.hi, bus.lo});
        end
        @(negedge clk); rst = 1'b1; @(negedge clk);
    endtask

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [4:0]   sh;
        logic [W-1:0] res;
        logic         z;
        logic         ov;
    } comb_t;

    task automatic test_comb();
        comb_t tbl[12];
        tbl[0]  = '{4'd0,  32'h7FFFFFFF, 32'h1,        5'd0,  32'h80000000, 1'b0, 1'b1};
        tbl[1]  = '{4'd1,  32'h5,        32'h5,        5'd0,  32'h0,        1'b1, 1'b0};
        tbl[2]  = '{4'd4,  32'hFFFFFFFF, 32'h1,        5'd0,  32'h1,        1'b0, 1'b0};
        tbl[3]  = '{4'd10, 32'hFFFFFFFF, 32'h1,        5'd0,  32'h0,        1'b1, 1'b0};
        tbl[4]  = '{4'd9,  32'h80000000, 32'h0,        5'd4,  32'hF8000000, 1'b0, 1'b0};
        tbl[5]  = '{4'd1,  32'h80000000, 32'h1,        5'd0,  32'h7FFFFFFF, 1'b0, 1'b1};
        tbl[6]  = '{4'd6,  32'h0,        32'h0,        5'd0,  32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[7]  = '{4'd7,  32'h1,        32'h0,        5'd31, 32'h80000000, 1'b0, 1'b0};
        tbl[8]  = '{4'd8,  32'h80000000, 32'h0,        5'd31, 32'h1,        1'b0, 1'b0};
        tbl[9]  = '{4'd5,  32'hA5A5A5A5, 32'hFFFFFFFF, 5'd0,  32'h5A5A5A5A, 1'b0, 1'b0};
        tbl[10] = '{4'd15, 32'h3,        32'h4,        5'd0,  32'h0,        1'b1, 1'b0};
        tbl[11] = '{4'd11, 32'h3,        32'h4,        5'd0,  32'h0,        1'b1, 1'b0};
        for (int i = 0; i < 12; i++) begin
            bus.opSel = tbl[i].op; bus.operand1 = tbl[i].a; bus.operand2 = tbl[i].b;
            bus.shamt = tbl[i].sh;
            #1;
            checks++;
            if (bus.result !== tbl[i].res) begin
                failures++; $display("FAIL comb[%0d] result got %08h want %08h", i, bus.result, tbl[i].res);
            end
            checks++;
            if (bus.zero !== tbl[i].z) begin
                failures++; $display("FAIL comb[%0d] zero got %0b want %0b", i, bus.zero, tbl[i].z);
            end
            checks++;
            if (bus.overflow !== tbl[i].ov) begin
                failures++; $display("FAIL comb[%0d] overflow got %0b want %0b", i, bus.overflow, tbl[i].ov);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_muldiv();
        int bc; bit both, tmo;
        logic [3:0]   ops[7] = '{4'd11, 4'd12, 4'd13, 4'd14, 4'd13, 4'd14, 4'd13};
        logic [W-1:0] as[7]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd9, 32'd17};
        logic [W-1:0] bs[7]  = '{32'd7, 32'hFFFFFFFF, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFC};
        for (int i = 0; i < 7; i++) begin
            launch(ops[i], as[i], bs[i]);
            collect(bc, both, tmo);
            check_result($sformatf("muldiv[%0d]", i), 1'b1, bc, both, tmo);
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.div_by_zero !== 1'b0) begin
                failures++; $display("FAIL muldiv[%0d] pulse_end done/dz got %0b%0b want 00", i, bus.done, bus.div_by_zero);
            end
        end
    endtask

    task automatic test_ignore_restart();
        int bc; bit both, tmo;
        launch(4'd14, 32'd100, 32'd7);
        repeat (5) @(negedge clk);
        bus.opSel = 4'd12; bus.operand1 = 32'hFFFFFFFF; bus.operand2 = 32'hFFFFFFFF; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.operand1 = 32'h12345678; bus.operand2 = 32'd3;
        collect(bc, both, tmo);
        check_result("ignore_restart", 1'b0, bc, both, tmo);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bc; bit both, tmo;
        launch(4'd11, 32'hFFFFFFFD, 32'd7);
        collect(bc, both, tmo);
        check_result("b2b_first", 1'b1, bc, both, tmo);
        launch(4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++; $display("FAIL b2b_rearm busy/done got %0b%0b want 10", bus.busy, bus.done);
        end
        collect(bc, both, tmo);
        check_result("b2b_second", 1'b1, bc, both, tmo);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int bc; bit both, tmo;
        exp_t dropped;
        launch(4'd11, 32'hFFFFFFFD, 32'd7);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        dropped = sb_q.pop_back();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            failures++; $display("FAIL midrst_flags busy/done got %0b%0b want 00", bus.busy, bus.done);
        end
        checks++;
        if ({bus.hi, bus.lo} !== 64'd0) begin
            failures++; $display("FAIL midrst_hilo got %016h want 0 (dropped %016h)", {bus.hi, bus.lo}, {dropped.hi, dropped.lo});
        end
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || {bus.hi, bus.lo} !== 64'd0) begin
            failures++; $display("FAIL midrst_idle busy/done/hilo got %0b%0b/%016h want 00/0", bus.busy, bus.done, {bus.hi, bus.lo});
        end
        launch(4'd14, 32'd100, 32'd7);
        collect(bc, both, tmo);
        check_result("after_midrst", 1'b1, bc, both, tmo);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_comb();
        test_muldiv();
        test_ignore_restart();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised successor to the single-cycle datapath ALU. Combinational ops resolve in the same cycle as before, extended with signed/unsigned compare, arithmetic shift and signed-overflow detection. An iterative multiply/divide unit writes HI/LO registers through a start/busy/done handshake. It sits in the execute stage; the controller stalls the pipeline on `busy` and reads HI/LO for MFHI/MFLO.

## Interface
- `WIDTH`, 32: datapath width, ≥ 4, even.
- `SHW`, $clog2(WIDTH): shift-amount width.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `operand1`, `operand2`  in  WIDTH  operands.
- `opSel`  in  4  operation select.
- `shamt`  in  SHW  shift amount.
- `start`  in  1  launch mul/div when `opSel` is 11–14.
- `result`  out  WIDTH  combinational result.
- `zero`  out  1  `result == 0`.
- `overflow`  out  1  signed overflow for ADD/SUB, else 0.
- `busy`  out  1  mul/div in progress.
- `done`  out  1  one-cycle completion pulse.
- `div_by_zero`  out  1  valid with `done`.
- `hi`, `lo`  out  WIDTH  HI/LO registers.

## Operation
- opSel codes:
  - 0 ADD: op1+op2.
  - 1 SUB: op1−op2.
  - 2 AND, 3 OR, 5 XOR, 6 NOR.
  - 4 SLT: signed compare.
  - 10 SLTU: unsigned compare.
  - 7 SLL, 8 SRL, 9 SRA: shift op1 by `shamt`.
  - 11 MULT, 12 MULTU, 13 DIV, 14 DIVU.
  - 15: reserved.
- `result` is 0 for codes 11–15. `zero` is derived from `result` in all cases.
- `overflow`:
  - ADD: operand signs equal and the sum sign differs.
  - SUB: operand signs differ and the difference sign differs from op1.
- FSM states: IDLE, RUN, DONE.
  - IDLE/DONE → RUN: `start` = 1 and opSel ∈ 11–14. Operands, op and signedness are latched; step counter is set to WIDTH.
  - `start` in RUN is ignored. `start` with any other opSel is ignored.
  - RUN: one radix-2 step per cycle, counter decrements. At the step where the counter is 1: HI/LO are written and the FSM goes to DONE.
  - DONE → IDLE after one cycle, unless a new start is accepted.
- Multiply:
  - Shift-add on magnitudes; the 2·WIDTH product is negated if the operand signs differ (signed only).
  - `{hi, lo}` = product.
- Divide:
  - Restoring division on magnitudes.
  - `lo` = quotient, negated if signs differ.
  - `hi` = remainder, sign follows dividend.
  - Most-negative / −1 gives `lo` = most-negative, `hi` = 0.
- Divide by zero: `lo` = all ones, `hi` = op1, `div_by_zero` = 1 during DONE.
- HI/LO change only on entry to DONE.

## Timing
- Reset (async, any state): FSM = IDLE, counter = 0, `hi` = `lo` = 0, `busy` = `done` = `div_by_zero` = 0. Reset mid-RUN discards the operation; HI/LO are not written.
- `result`, `zero`, `overflow`: zero latency, no registers.
- Start accepted at edge E0.
- `busy` = 1 from after E0 until the edge EWIDTH, i.e. exactly WIDTH cycles.
- `done` = 1 for the single cycle after EWIDTH; new HI/LO are visible in that cycle.
- `busy` and `done` are never both 1.
- A back-to-back start accepted in DONE re-asserts `busy` on the next cycle.
- Latched operands are used throughout RUN; operand changes after E0 have no effect.

## Test plan
- WIDTH=32 combinational sweep:
  - ADD 0x7FFFFFFF+1 → 0x80000000, overflow=1.
  - SUB 5−5 → 0, zero=1.
  - SLT −1<1 → 1; SLTU 0xFFFFFFFF<1 → 0.
  - SRA 0x80000000 by 4 → 0xF8000000.
- MULT −3×7, start pulsed one cycle → busy for 32 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULTU 0xFFFFFFFF² → hi=0xFFFFFFFE, lo=1.
- DIV −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2. DIV 0x80000000/−1 → lo=0x80000000, hi=0.
- DIVU 9/0 → lo=0xFFFFFFFF, hi=9, div_by_zero=1 with done.
- Start re-pulsed mid-RUN and operands changed → ignored, original result kept. Back-to-back start in the DONE cycle → second result after another 32 busy cycles.
- rst low at RUN cycle 10 → busy=0, hi/lo unchanged from reset value 0, FSM IDLE. Next start runs normally.
